// File: rtl/ctl_seq.sv
// rtl/ctl_seq.sv - multi-cycle control sequencer driving the register bank write port
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   op_valid/ready  op handshake; ctl_op, reg_sel, src_sel, imm sampled on accept
//   bus_in/valid    narrow data beats for CTL_BUS_LOAD, little-endian
//   regbank_rsel    bank read select; regbank_valin returns one cycle later
//   regbank_we/sel/valout  bank write port; we is a single-cycle pulse
//   busy            sequencer is not idle
//   err_illegal     one-cycle pulse after an unknown opcode is accepted
module ctl_seq #(
    parameter int DATA_W = 64,
    parameter int SEL_W  = 6,
    parameter int OP_W   = 8,
    parameter int BUS_W  = 8,
    parameter logic [OP_W-1:0] CTL_NOP      = 8'h00,
    parameter logic [OP_W-1:0] CTL_LOAD_IMM = 8'h01,
    parameter logic [OP_W-1:0] CTL_MOV      = 8'h02,
    parameter logic [OP_W-1:0] CTL_BUS_LOAD = 8'h03
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   ctl_op,
    input  logic [SEL_W-1:0]  reg_sel,
    input  logic [SEL_W-1:0]  src_sel,
    input  logic [DATA_W-1:0] imm,
    input  logic [BUS_W-1:0]  bus_in,
    input  logic              bus_valid,
    output logic [SEL_W-1:0]  regbank_rsel,
    input  logic [DATA_W-1:0] regbank_valin,
    output logic              regbank_we,
    output logic [SEL_W-1:0]  regbank_sel,
    output logic [DATA_W-1:0] regbank_valout,
    output logic              busy,
    output logic              err_illegal
);

    localparam int BEATS = DATA_W / BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_WRITE   = 2'd3;

    logic [1:0]               state;
    logic [SEL_W-1:0]         dst;
    logic [SEL_W-1:0]         rsel_q;
    logic [SEL_W-1:0]         sel_q;
    logic [DATA_W-1:0]        data;
    logic [DATA_W-1:0]        val_q;
    logic [CNT_W-1:0]         cnt;
    logic                     err_q;
    logic                     accept;
    logic                     mov_offer;
    logic [DATA_W+BUS_W-1:0]  shift_cat;

    assign op_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = op_valid && op_ready;
    assign mov_offer = accept && (ctl_op == CTL_MOV);

    // New beat enters at the top; after the last beat the first one sits in the low bits.
    assign shift_cat = {bus_in, data};

    // The bank read is synchronous, so the source select is passed through during
    // the accept cycle; the bank then returns the value in the READ cycle.
    assign regbank_rsel = mov_offer ? src_sel : rsel_q;

    // Write port shows the pending write during WRITE and holds the last write otherwise.
    assign regbank_we     = (state == ST_WRITE);
    assign regbank_sel    = (state == ST_WRITE) ? dst  : sel_q;
    assign regbank_valout = (state == ST_WRITE) ? data : val_q;
    assign err_illegal    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            dst    <= '0;
            rsel_q <= '0;
            sel_q  <= '0;
            data   <= '0;
            val_q  <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dst <= reg_sel;
                        case (ctl_op)
                            CTL_NOP: ;
                            CTL_LOAD_IMM: begin
                                data  <= imm;
                                state <= ST_WRITE;
                            end
                            CTL_MOV: begin
                                rsel_q <= src_sel;
                                state  <= ST_READ;
                            end
                            CTL_BUS_LOAD: begin
                                cnt   <= '0;
                                data  <= '0;
                                state <= ST_COLLECT;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                ST_READ: begin
                    data  <= regbank_valin;
                    state <= ST_WRITE;
                end
                ST_COLLECT: begin
                    if (bus_valid) begin
                        data <= shift_cat[DATA_W+BUS_W-1:BUS_W];
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == LAST_BEAT) begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    sel_q <= dst;
                    val_q <= data;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctl_seq.sv
// tb/tb_ctl_seq.sv - directed self-checking bench for ctl_seq
module tb_ctl_seq;

    localparam logic [7:0] NOP  = 8'h00;
    localparam logic [7:0] LDI  = 8'h01;
    localparam logic [7:0] MOV  = 8'h02;
    localparam logic [7:0] BUSL = 8'h03;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  ctl_op;
    logic [5:0]  reg_sel;
    logic [5:0]  src_sel;
    logic [63:0] imm;
    logic [7:0]  bus_in;
    logic        bus_valid;
    logic [5:0]  regbank_rsel;
    logic [63:0] regbank_valin;
    logic        regbank_we;
    logic [5:0]  regbank_sel;
    logic [63:0] regbank_valout;
    logic        busy;
    logic        err_illegal;

    ctl_seq dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .ctl_op(ctl_op), .reg_sel(reg_sel), .src_sel(src_sel), .imm(imm),
        .bus_in(bus_in), .bus_valid(bus_valid),
        .regbank_rsel(regbank_rsel), .regbank_valin(regbank_valin),
        .regbank_we(regbank_we), .regbank_sel(regbank_sel), .regbank_valout(regbank_valout),
        .busy(busy), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] mem [64];
    always @(posedge clk) begin
        regbank_valin <= mem[regbank_rsel];
        if (regbank_we) mem[regbank_sel] <= regbank_valout;
    end

    int          wr_cyc [$];
    logic [5:0]  wr_sel [$];
    logic [63:0] wr_val [$];
    always @(negedge clk) begin
        if (!rst && regbank_we) begin
            wr_cyc.push_back(cyc);
            wr_sel.push_back(regbank_sel);
            wr_val.push_back(regbank_valout);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input int exp_cyc,
                               input logic [5:0] sel, input logic [63:0] val);
        check({tag, "_cyc"}, wr_cyc[idx], exp_cyc);
        check({tag, "_sel"}, wr_sel[idx], sel);
        check({tag, "_val"}, wr_val[idx], val);
    endtask

    // Called at a negedge; returns at the negedge one cycle after the accept cycle.
    task automatic issue(input logic [7:0] op, input logic [5:0] dst, input logic [5:0] src,
                         input logic [63:0] iv, output int acc);
        int n;
        ctl_op = op; reg_sel = dst; src_sel = src; imm = iv; op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", n < 20, 1'b1);
        acc = cyc;
        @(negedge clk);
        op_valid = 1'b0;
        ctl_op = NOP;
    endtask

    task automatic beat(input logic [7:0] b);
        bus_in = b;
        bus_valid = 1'b1;
        @(negedge clk);
        bus_valid = 1'b0;
        bus_in = 8'hFF;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, acc2, nw;
        for (int i = 0; i < 64; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        mem[3] = 64'h1122_3344_5566_7788;

        rst = 1'b1; op_valid = 1'b0; ctl_op = NOP; reg_sel = '0; src_sel = '0;
        imm = '0; bus_in = '0; bus_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", op_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_we", regbank_we, 1'b0);
        check("rst_sel", regbank_sel, 6'd0);
        check("rst_val", regbank_valout, 64'd0);
        check("rst_rsel", regbank_rsel, 6'd0);
        check("rst_err", err_illegal, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // LOAD_IMM: write one cycle after accept
        issue(LDI, 6'd5, 6'd0, 64'hDEAD_BEEF_0123_4567, acc);
        check("ldi_we", regbank_we, 1'b1);
        check("ldi_ready_low", op_ready, 1'b0);
        @(negedge clk);
        check("ldi_we_drop", regbank_we, 1'b0);
        check("ldi_ready_back", op_ready, 1'b1);
        check("ldi_hold_val", regbank_valout, 64'hDEAD_BEEF_0123_4567);
        check("ldi_nwr", wr_cyc.size(), 1);
        check_write("ldi", 0, acc + 1, 6'd5, 64'hDEAD_BEEF_0123_4567);

        // MOV 3 -> 9 through the synchronous read port
        issue(MOV, 6'd9, 6'd3, 64'd0, acc);
        check("mov_rsel", regbank_rsel, 6'd3);
        check("mov_no_early_we", regbank_we, 1'b0);
        repeat (2) @(negedge clk);
        check("mov_nwr", wr_cyc.size(), 2);
        check_write("mov", 1, acc + 2, 6'd9, 64'h1122_3344_5566_7788);

        // BUS_LOAD with a 3-cycle stall after beat 4
        issue(BUSL, 6'd1, 6'd0, 64'd0, acc);
        for (int b = 1; b <= 4; b++) beat(8'(b));
        repeat (3) @(negedge clk);
        check("busl_no_early_wr", wr_cyc.size(), 2);
        for (int b = 5; b <= 8; b++) beat(8'(b));
        @(negedge clk);
        check("busl_nwr", wr_cyc.size(), 3);
        check_write("busl", 2, acc + 12, 6'd1, 64'h0807_0605_0403_0201);

        // Illegal opcode, then back-to-back NOPs
        issue(8'h7F, 6'd2, 6'd0, 64'd0, acc);
        check("ill_err", err_illegal, 1'b1);
        check("ill_ready", op_ready, 1'b1);
        @(negedge clk);
        check("ill_err_drop", err_illegal, 1'b0);
        ctl_op = NOP; op_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nop_ready", op_ready, 1'b1);
            check("nop_busy", busy, 1'b0);
        end
        op_valid = 1'b0;
        @(negedge clk);
        check("ill_nop_nwr", wr_cyc.size(), 3);

        // Async reset in the middle of a bus load
        issue(BUSL, 6'd2, 6'd0, 64'd0, acc);
        for (int b = 0; b < 3; b++) beat(8'hE0 + 8'(b));
        #2 rst = 1'b1;
        #1;
        check("arst_ready", op_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_sel", regbank_sel, 6'd0);
        check("arst_val", regbank_valout, 64'd0);
        check("arst_rsel", regbank_rsel, 6'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nw = wr_cyc.size();
        check("arst_no_wr", nw, 3);
        issue(BUSL, 6'd2, 6'd0, 64'd0, acc);
        for (int b = 0; b < 7; b++) beat(8'h10 + 8'(b));
        check("arst_7beats_no_wr", wr_cyc.size(), nw);
        beat(8'h17);
        @(negedge clk);
        check("arst_full_nwr", wr_cyc.size(), nw + 1);
        check_write("arst_busl", nw, acc + 9, 6'd2, 64'h1716_1514_1312_1110);

        // LOAD_IMM held off during a MOV, written after the MOV in order
        nw = wr_cyc.size();
        issue(MOV, 6'd4, 6'd9, 64'd0, acc);
        ctl_op = LDI; op_valid = 1'b1;
        check("hold_ready_low", op_ready, 1'b0);
        issue(LDI, 6'd7, 6'd0, 64'hCAFE_F00D_0000_0042, acc2);
        check("hold_acc_cycle", acc2, acc + 3);
        @(negedge clk);
        check("hold_nwr", wr_cyc.size(), nw + 2);
        check_write("hold_mov", nw, acc + 2, 6'd4, 64'h1122_3344_5566_7788);
        check_write("hold_ldi", nw + 1, acc + 4, 6'd7, 64'hCAFE_F00D_0000_0042);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctl_seq.md
Name: ctl_seq

Overview:
- Parametrised, multi-cycle successor to the processor control unit.
- Accepts control operations over a valid/ready handshake and sequences them through a small FSM to drive the register bank write port.
- Supported operations: immediate load, register-to-register move through the bank's synchronous read port, and multi-beat assembly of a register value from the narrow data bus.
- Sits between the instruction decode front end and the register bank.

Parameters:
- DATA_W, 64, register/immediate width.
- SEL_W, 6, register select width (2^SEL_W registers).
- OP_W, 8, control opcode width.
- BUS_W, 8, bus_in width. DATA_W % BUS_W must be 0.
- CTL_NOP, 8'h00, no operation.
- CTL_LOAD_IMM, 8'h01, dst <= imm.
- CTL_MOV, 8'h02, dst <= src.
- CTL_BUS_LOAD, 8'h03, dst <= DATA_W/BUS_W bus beats, little-endian.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  op fields valid.
- op_ready  out  1  ctl_seq can accept an op.
- ctl_op  in  OP_W  opcode.
- reg_sel  in  SEL_W  destination register.
- src_sel  in  SEL_W  source register (CTL_MOV only).
- imm  in  DATA_W  immediate (CTL_LOAD_IMM only).
- bus_in  in  BUS_W  bus data beat.
- bus_valid  in  1  bus_in holds a valid beat this cycle.
- regbank_rsel  out  SEL_W  register bank read select.
- regbank_valin  in  DATA_W  register bank read data; valid 1 cycle after regbank_rsel is presented.
- regbank_we  out  1  register bank write enable, single-cycle pulse.
- regbank_sel  out  SEL_W  register bank write select.
- regbank_valout  out  DATA_W  register bank write data.
- busy  out  1  FSM is not in IDLE.
- err_illegal  out  1  one-cycle pulse for an unknown opcode.

Behaviour:
- Reset (async assert, any state): FSM goes to IDLE; beat counter and shift register cleared.
  - Outputs: regbank_we=0, regbank_sel=0, regbank_valout=0, regbank_rsel=0, err_illegal=0, busy=0, op_ready=1.
  - An op in flight is aborted with no write.
- op_ready = (state==IDLE). Accept = op_valid && op_ready at a posedge; ctl_op, reg_sel, src_sel and imm are latched at accept. Inputs are ignored when not ready.
- States: IDLE, READ, COLLECT, WRITE.
- IDLE, on accept:
  - NOP: stay IDLE, no side effects.
  - LOAD_IMM: go to WRITE with data=imm.
  - MOV: drive regbank_rsel=src_sel; go to READ.
  - BUS_LOAD: clear counter; go to COLLECT.
  - Other opcode: err_illegal=1 for the following cycle only; stay IDLE.
- READ (1 cycle): capture regbank_valin as data; go to WRITE.
- COLLECT:
  - Each cycle with bus_valid=1: shift register <= {bus_in, shreg[DATA_W-1:BUS_W]}; counter++.
  - The first beat ends up in bits [BUS_W-1:0].
  - When the final beat (counter == DATA_W/BUS_W - 1) is taken, go to WRITE.
  - bus_valid=0 cycles stall indefinitely. bus_valid is ignored outside COLLECT.
- WRITE (1 cycle): regbank_we=1, regbank_sel=latched reg_sel, regbank_valout=data; next state IDLE.
- regbank_we is 0 in every other cycle. regbank_sel and regbank_valout hold their last written values between writes.
- Latency from accept edge to the cycle where regbank_we=1:
  - LOAD_IMM: 1 cycle.
  - MOV: 2 cycles.
  - BUS_LOAD: (beats+stall cycles) + 1.
- Throughput: at most one op per 2 cycles, except NOP, which is 1 per cycle.
- MOV with src_sel==reg_sel is legal and writes back the read value.
- An op offered during WRITE is held off (op_ready=0) and accepted in the next IDLE cycle.

Test Plan:
- Reset, then accept LOAD_IMM reg_sel=5, imm=64'hDEAD_BEEF_0123_4567 -> exactly one cycle with regbank_we=1, sel=5, valout=64'hDEAD_BEEF_0123_4567, 1 cycle after accept; op_ready low for 1 cycle.
- MOV src_sel=3 -> reg_sel=9, bank model returns 64'h1122_3344_5566_7788 for reg 3 -> regbank_rsel=3, then a write of 64'h1122_3344_5566_7788 to sel=9, 2 cycles after accept.
- BUS_LOAD reg_sel=1 with beats 8'h01..8'h08 and bus_valid dropped for 3 cycles after beat 4 -> single write, valout=64'h0807_0605_0403_0201, 12 cycles after accept; no write earlier.
- ctl_op=8'h7F with op_valid -> err_illegal high 1 cycle, regbank_we never asserts, op_ready stays 1; back-to-back NOPs are accepted every cycle.
- Assert rst mid-COLLECT after 3 beats -> outputs at reset values immediately (async); no write. A following BUS_LOAD needs a full 8 beats.
- op_valid held with LOAD_IMM during an ongoing MOV -> LOAD_IMM accepted only after the MOV write cycle, and its write follows in order.
